mul_iter_unit: RTL and testbench
================================

Name: mul_iter_unit

Overview:
- Iterative 32x32 multiplier serving LoongArch MUL.W, MULH.W and MULH.WU.
- Sits directly downstream of the execute stage and is launched by its CAL_MUL decode.
- Holds the pipeline through a stall request while it computes, then returns a 32-bit result to the EX/MEM path.
- Uses a shift-add datapath on operand magnitudes, with a final sign fix.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  launch request (EX valid and CAL_MUL).
- mul_op  input  2  00 MUL.W (low word); 01 MULH.W (signed high); 10 MULH.WU (unsigned high); 11 reserved, treated as 00.
- src_a  input  WIDTH  multiplicand (forwarded src1).
- src_b  input  WIDTH  multiplier (forwarded src2).
- flush  input  1  abort the current operation (mispredict or exception).
- stall_req  output  1  freeze upstream stages.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  product word; held until the next completion.

Behaviour:
- State machine: IDLE, CALC, FIX, DONE.
- Reset (rst=0 at an edge): state=IDLE, count=0, done=0, result=0, internal registers=0. Reset mid-operation discards it with no done pulse.
- Acceptance: start is accepted when state is IDLE or DONE and flush=0.
- On acceptance:
  - latch the op;
  - latch |src_a| and |src_b| when the op is signed, raw operands otherwise;
  - latch neg = sign(a) XOR sign(b) for signed ops, 0 otherwise;
  - clear the 64-bit accumulator and set count=0;
  - next state CALC.
- CALC, once per cycle:
  - if multiplier LSB=1, add the shifted multiplicand into the accumulator;
  - shift the multiplier right by 1 and the multiplicand left by 1;
  - count += 1.
  - After WIDTH iterations (count == WIDTH-1 at the edge), next state is FIX.
- FIX: if neg, accumulator := two's complement (64-bit wrap). result := acc[31:0] for 00/11 and acc[63:32] for 01/10. Next state DONE.
- DONE: done=1 for exactly one cycle.
  - Next state IDLE, or CALC if a new start is accepted in the same cycle (back-to-back, no bubble).
- Latency: start in cycle 0; CALC in cycles 1..32; FIX in cycle 33; done in cycle 34.
- stall_req is combinational:
  - stall_req = (start AND state in {IDLE, DONE} AND NOT flush) OR state in {CALC, FIX};
  - it is high in cycles 0..33 and low in cycle 34, so EX advances with the result.
- Flush:
  - in any state, next state is IDLE, done is suppressed, and result keeps its prior value;
  - flush and start in the same cycle: flush wins and start is ignored;
  - stall_req drops in the same cycle that flush is high.
- Corner cases:
  - Operand 0x80000000 signed: its magnitude 0x80000000 fits unsigned 32 bits; no overflow special case.
  - A zero product with neg=1 negates to 0; no special case.
- start while in CALC/FIX is ignored; upstream is stalled, so it only sees a held request.

Optional Feature:
- MUL_EARLY_OUT_EN
- Defined: CALC exits to FIX at the edge where the shifted multiplier register becomes zero, or after WIDTH iterations, whichever is first.
  - Minimum of 1 CALC cycle.
  - Latency = 2 + (index of highest set bit of |b|) + 1. For example, b=3 gives done in cycle 4.
  - b=0 gives 1 CALC cycle with done in cycle 3.
- Undefined: fixed 34-cycle latency for every operand.

Decomposition:
- Shared package holds:
  - MUL_OP_W=2'b00, MULH_W=2'b01, MULH_WU=2'b10;
  - the state encoding for IDLE/CALC/FIX/DONE;
  - the WIDTH default.
- Sub-module mul_abs_sign: combinational magnitude and sign extraction for both operands given the signed flag. It is reused by the future divider.
- The FSM, datapath and counter stay in mul_iter_unit.

Test Plan:
- MUL.W, a=7, b=0xFFFFFFFD (-3) -> done in cycle 34, result=0xFFFFFFEB; stall_req high in cycles 0..33 only.
- MULH.W, a=b=0x80000000 -> result=0x40000000; MULH.W, a=b=0xFFFFFFFF -> result=0x00000000.
- MULH.WU, a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MUL.W with the same operands -> 0x00000001.
- Flush in cycle 10 of an operation -> no done pulse, stall_req low from cycle 10, result keeps its previous value. Flush together with start -> no launch.
- Back-to-back: second start asserted in the DONE cycle -> first done in cycle 34, second done in cycle 68. Reset (rst=0) in cycle 20 -> all outputs 0 next cycle and no done pulse.
- With MUL_EARLY_OUT_EN, MUL.W a=5, b=3 -> result=15, done in cycle 4. Without it -> done in cycle 34.

Source files
------------

// File: rtl/mul_iter_unit_pkg.sv
// rtl/mul_iter_unit_pkg.sv - shared op codes, state encoding and width default for the iterative multiplier
package mul_iter_unit_pkg;

    localparam int WIDTH_DEF = 32;

    // mul_op encodings; 2'b11 is reserved and behaves as MUL_OP_W
    localparam logic [1:0] MUL_OP_W = 2'b00;
    localparam logic [1:0] MULH_W   = 2'b01;
    localparam logic [1:0] MULH_WU  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_t;

endpackage

// File: rtl/mul_abs_sign.sv
// rtl/mul_abs_sign.sv - combinational operand magnitude and product sign extraction
//
// Ports:
//   is_signed  treat operands as two's complement
//   a, b       raw operands
//   mag_a      |a| when signed, a otherwise
//   mag_b      |b| when signed, b otherwise
//   neg        sign(a) XOR sign(b) when signed, 0 otherwise
//
// The most negative value maps to itself, which is its correct unsigned magnitude.
module mul_abs_sign #(
    parameter int WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg
);

    logic neg_a;
    logic neg_b;

    assign neg_a = is_signed & a[WIDTH-1];
    assign neg_b = is_signed & b[WIDTH-1];

    assign mag_a = neg_a ? (~a + WIDTH'(1)) : a;
    assign mag_b = neg_b ? (~b + WIDTH'(1)) : b;
    assign neg   = neg_a ^ neg_b;

endmodule

// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - iterative shift-add 32x32 multiplier for MUL.W / MULH.W / MULH.WU
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      launch request from EX
//   mul_op     00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 as 00
//   src_a      multiplicand
//   src_b      multiplier
//   flush      abort current operation, wins over start
//   stall_req  combinational freeze request to upstream stages
//   done       one-cycle completion pulse
//   result     product word, held until the next completion
//
// Optional build macro MUL_EARLY_OUT_EN: leave CALC as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH iterations.
module mul_iter_unit
    import mul_iter_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mul_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int ACC_W = 2 * WIDTH;

    mul_state_t state;
    mul_state_t state_n;

    logic [1:0]       op_q;
    logic             neg_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             calc_last;
    logic             op_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic [ACC_W-1:0] acc_fixed;
    logic             take_high;

    // MUL.W is a signed multiply; its low word is the same either way, but
    // using magnitudes keeps the early-out latency tied to |b|.
    assign op_signed = (mul_op != MULH_WU);

    mul_abs_sign #(.WIDTH(WIDTH)) u_abs_sign (
        .is_signed (op_signed),
        .a         (src_a),
        .b         (src_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg       (neg)
    );

`ifdef MUL_EARLY_OUT_EN
    // Exit once the multiplier will be zero after this cycle's shift.
    assign calc_last = (count == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign calc_last = (count == CNT_W'(WIDTH - 1));
`endif

    assign acc_fixed = neg_q ? (~acc + ACC_W'(1)) : acc;
    assign take_high = (op_q == MULH_W) || (op_q == MULH_WU);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_n = ST_CALC;
                ST_CALC: if (calc_last) state_n = ST_FIX;
                ST_FIX:  state_n = ST_DONE;
                ST_DONE: state_n = start ? ST_CALC : ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        accept    = 1'b0;
        stall_req = 1'b0;
        done      = 1'b0;
        if (!flush) begin
            accept    = start && (state == ST_IDLE || state == ST_DONE);
            stall_req = accept || state == ST_CALC || state == ST_FIX;
            done      = (state == ST_DONE);
        end
    end

    // Datapath and iteration counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
        end else if (accept) begin
            op_q   <= mul_op;
            neg_q  <= neg;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            count  <= '0;
        end else if (!flush) begin
            if (state == ST_CALC) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CNT_W'(1);
            end else if (state == ST_FIX) begin
                acc    <= acc_fixed;
                result <= take_high ? acc_fixed[ACC_W-1:WIDTH] : acc_fixed[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// tb/tb_mul_iter_unit.sv - self-checking bench for mul_iter_unit
module tb_mul_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mul_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_iter_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mul_op    (mul_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        logic [63:0]     w;
        case (op)
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                w  = sp;
                return w[63:32];
            end
            2'b10: begin
                up = {32'b0, a} * {32'b0, b};
                w  = up;
                return w[63:32];
            end
            default: return a * b;
        endcase
    endfunction

    // Cycle (relative to the start cycle) in which done is expected
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] m;
        int          hsb;
        m   = (op != 2'b10 && b[31]) ? (~b + 32'd1) : b;
        hsb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hsb = i;
        return 3 + hsb;
`else
        return 34 + 0 * int'(op) + 0 * int'(b[0]);
`endif
    endfunction

    // Launch one op in the current cycle, track stall/done until completion
    task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int          lat;
        bit          stall_ok;
        logic [31:0] res;
        lat      = -1;
        stall_ok = 1'b1;
        res      = '0;
        start  = 1'b1;
        mul_op = op;
        src_a  = a;
        src_b  = b;
        #1;
        if (!stall_req) stall_ok = 1'b0;
        step();
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                lat = k;
                res = result;
                if (stall_req) stall_ok = 1'b0;
                break;
            end
            if (!stall_req) stall_ok = 1'b0;
            step();
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 100 cycles", name);
            return;
        end
        chk({name, "_result"}, res, exp);
        chk({name, "_latency"}, lat, exp_lat(op, b));
        chk({name, "_stall"}, {31'b0, stall_ok}, 32'd1);
        step();
        chk({name, "_done_width"}, {31'b0, done}, 32'd0);
        chk({name, "_hold"}, result, exp);
    endtask

    vec_t        vecs[8];
    logic [31:0] prev;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          done_cyc[$];
    logic [31:0] done_res[$];
    bit          bad;

    initial begin
        vecs[0] = '{2'b00, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1] = '{2'b01, 32'h80000000,  32'h80000000, 32'h40000000};
        vecs[2] = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{2'b10, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4] = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001};
        vecs[5] = '{2'b11, 32'd5,         32'd3,        32'd15};
        vecs[6] = '{2'b01, 32'h80000000,  32'd1,        32'hFFFFFFFF};
        vecs[7] = '{2'b01, 32'd0,         32'h80000000, 32'h00000000};

        rst = 1'b0; start = 1'b0; mul_op = '0; src_a = '0; src_b = '0; flush = 1'b0;
        step(); step();
        chk("reset_stall", {31'b0, stall_req}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 12; i++) begin
            ra  = $urandom;
            rb  = (i % 3 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            rop = 2'($urandom_range(0, 3));
            run_check($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
        end

        // Flush in cycle 10: no done, stall drops immediately, result held
        prev   = result;
        start  = 1'b1; mul_op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        step();
        start  = 1'b0;
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1;
        #1;
        chk("flush_stall_same_cycle", {31'b0, stall_req}, 32'd0);
        chk("flush_done_same_cycle", {31'b0, done}, 32'd0);
        step();
        flush = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done || stall_req) bad = 1'b1;
            step();
        end
        chk("flush_no_done", {31'b0, bad}, 32'd0);
        chk("flush_result_kept", result, prev);

        // Flush together with start: no launch
        start = 1'b1; flush = 1'b1; src_a = 32'd2; src_b = 32'd2;
        #1;
        chk("flush_start_stall", {31'b0, stall_req}, 32'd0);
        step();
        start = 1'b0; flush = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done || stall_req) bad = 1'b1;
            step();
        end
        chk("flush_start_no_launch", {31'b0, bad}, 32'd0);

        // Back-to-back: second start in the first DONE cycle
        start = 1'b1; mul_op = 2'b00; src_a = 32'd11; src_b = 32'd13;
        step();
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                done_cyc.push_back(k);
                done_res.push_back(result);
                if (done_cyc.size() == 1) begin
                    start = 1'b1; mul_op = 2'b10; src_a = 32'hFFFF0000; src_b = 32'h00010000;
                end
            end
            step();
            start = 1'b0;
        end
        chk("b2b_done_count", done_cyc.size(), 32'd2);
        if (done_cyc.size() == 2) begin
            chk("b2b_first_cycle", done_cyc[0], exp_lat(2'b00, 32'd13));
            chk("b2b_first_result", done_res[0], 32'd143);
            chk("b2b_second_cycle", done_cyc[1], exp_lat(2'b00, 32'd13) + exp_lat(2'b10, 32'h00010000));
            chk("b2b_second_result", done_res[1], model(2'b10, 32'hFFFF0000, 32'h00010000));
        end

        // Reset in cycle 20 discards the operation
        start = 1'b1; mul_op = 2'b01; src_a = 32'h12345678; src_b = 32'h9ABCDEF0;
        step();
        start = 1'b0;
        for (int k = 1; k < 20; k++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_mid_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) bad = 1'b1;
            step();
        end
        chk("rst_mid_no_done", {31'b0, bad}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
